orderbook_cmd_sched: RTL and testbench

//  Multi-port command scheduler in front of the orderbook. Round-robin arbitrates NUM_PORTS requester

---
 rtl/orderbook_cmd_sched.sv | 194 +++++++++++++++++++
 tb/tb_orderbook_cmd_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/orderbook_cmd_sched.sv
// Round-robin command scheduler for the orderbook op bus with post-add/match drain.
// Optional OB_SCHED_PRIO_EN: port 0 gets strict priority, ports 1..N-1 round-robin.
module orderbook_cmd_sched #(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_SIZE    = 64,
  parameter int FIFO_SIZE    = 64,
  parameter int PRICE_LEVELS = 256,
  parameter int MAX_QUEUES   = 1024,
  parameter int MATCH_LIMIT  = 64,
  localparam int PTR_WIDTH   = $clog2(FIFO_SIZE),
  localparam int PRICE_WIDTH = $clog2(PRICE_LEVELS),
  localparam int PTR_QUEUE   = $clog2(MAX_QUEUES),
  localparam int PORT_W      = $clog2(NUM_PORTS),
  localparam int CMD_W       = 3 + 1 + PRICE_WIDTH + PTR_QUEUE + PTR_WIDTH + DATA_SIZE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       req_valid,
  output logic [NUM_PORTS-1:0]       req_ready,
  input  logic [NUM_PORTS*CMD_W-1:0] req_cmd,
  output logic [2:0]                 ob_op_flag,
  output logic                       ob_side,
  output logic [PRICE_WIDTH-1:0]     ob_price,
  output logic [PTR_QUEUE-1:0]       ob_q_index,
  output logic [PTR_WIDTH-1:0]       ob_index,
  output logic [DATA_SIZE-1:0]       ob_data,
  output logic [PORT_W-1:0]          ob_src,
  input  logic                       ob_matching,
  output logic                       busy,
  output logic                       bad_cmd,
  output logic                       match_timeout
);

  localparam int CNT_W = $clog2(MATCH_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MATCH} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PORT_W-1:0]      rr_q, rr_d;
  logic [2:0]             flag_q, flag_d;
  logic                   side_q, side_d;
  logic [PRICE_WIDTH-1:0] price_q, price_d;
  logic [PTR_QUEUE-1:0]   qidx_q, qidx_d;
  logic [PTR_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic [PORT_W-1:0]      src_q, src_d;
  logic                   busy_q, busy_d;
  logic                   bad_q, bad_d;
  logic                   to_q, to_d;

  logic                   grant_vld;
  logic [PORT_W-1:0]      grant;
  logic [CMD_W-1:0]       sel;
  logic [2:0]             sel_op;

`ifdef OB_SCHED_PRIO_EN
  int unsigned base;

  // rr_q of 0 (reset or wrap) means "start the 1..N-1 ring at port 1".
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    base      = (rr_q == '0) ? 0 : 32'(rr_q) - 1;
    for (int unsigned k = NUM_PORTS - 1; k > 0; k--) begin
      if (req_valid[PORT_W'(1 + ((base + k - 1) % (NUM_PORTS - 1)))]) begin
        grant_vld = 1'b1;
        grant     = PORT_W'(1 + ((base + k - 1) % (NUM_PORTS - 1)));
      end
    end
    if (req_valid[0]) begin
      grant_vld = 1'b1;
      grant     = '0;
    end
  end
`else
  // Scan from the far end so the nearest valid port at or after rr_q wins last.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int unsigned k = NUM_PORTS; k > 0; k--) begin
      if (req_valid[PORT_W'((32'(rr_q) + k - 1) % NUM_PORTS)]) begin
        grant_vld = 1'b1;
        grant     = PORT_W'((32'(rr_q) + k - 1) % NUM_PORTS);
      end
    end
  end
`endif

  assign sel    = req_cmd[32'(grant)*CMD_W +: CMD_W];
  assign sel_op = sel[CMD_W-1 -: 3];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    flag_d    = 3'b000;
    side_d    = side_q;
    price_d   = price_q;
    qidx_d    = qidx_q;
    idx_d     = idx_q;
    data_d    = data_q;
    src_d     = src_q;
    bad_d     = 1'b0;
    to_d      = to_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          req_ready[grant] = 1'b1;
`ifdef OB_SCHED_PRIO_EN
          if (grant != '0) rr_d = PORT_W'((32'(grant) + 1) % NUM_PORTS);
`else
          rr_d = PORT_W'((32'(grant) + 1) % NUM_PORTS);
`endif
          if (!sel_op[2]) begin
            bad_d = 1'b1;
          end else begin
            flag_d  = sel_op;
            side_d  = sel[CMD_W-4];
            price_d = sel[CMD_W-5 -: PRICE_WIDTH];
            qidx_d  = sel[DATA_SIZE+PTR_WIDTH +: PTR_QUEUE];
            idx_d   = sel[DATA_SIZE +: PTR_WIDTH];
            data_d  = sel[DATA_SIZE-1:0];
            src_d   = grant;
            if (sel_op[1] == 1'b0) state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        state_d = S_MATCH;
        cnt_d   = '0;
      end
      S_MATCH: begin
        if (!ob_matching) begin
          state_d = S_IDLE;
        end else if (cnt_q < CNT_W'(MATCH_LIMIT)) begin
          flag_d = 3'b101;
          cnt_d  = cnt_q + 1'b1;
        end else begin
          to_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    if (reset) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      flag_q  <= '0;
      side_q  <= 1'b0;
      price_q <= '0;
      qidx_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      busy_q  <= 1'b0;
      bad_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      flag_q  <= flag_d;
      side_q  <= side_d;
      price_q <= price_d;
      qidx_q  <= qidx_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
      bad_q   <= bad_d;
      to_q    <= to_d;
    end
  end

  assign ob_op_flag    = flag_q;
  assign ob_side       = side_q;
  assign ob_price      = price_q;
  assign ob_q_index    = qidx_q;
  assign ob_index      = idx_q;
  assign ob_data       = data_q;
  assign ob_src        = src_q;
  assign busy          = busy_q;
  assign bad_cmd       = bad_q;
  assign match_timeout = to_q;

endmodule

// File: tb/tb_orderbook_cmd_sched.sv
// Directed bench for orderbook_cmd_sched with a cycle-by-cycle reference model.
module tb_orderbook_cmd_sched;
  localparam int NP = 4, DS = 16, FS = 16, PL = 256, MQ = 16, ML = 4;
  localparam int PW = 4, PRW = 8, QW = 4, SW = 2;
  localparam int CW = 3 + 1 + PRW + QW + PW + DS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NP-1:0] req_valid = '0;
  logic [NP-1:0] req_ready;
  logic [NP*CW-1:0] req_cmd = '0;
  logic [2:0] ob_op_flag;
  logic ob_side;
  logic [PRW-1:0] ob_price;
  logic [QW-1:0] ob_q_index;
  logic [PW-1:0] ob_index;
  logic [DS-1:0] ob_data;
  logic [SW-1:0] ob_src;
  logic ob_matching = 1'b0;
  logic busy, bad_cmd, match_timeout;

  orderbook_cmd_sched #(
    .NUM_PORTS(NP), .DATA_SIZE(DS), .FIFO_SIZE(FS),
    .PRICE_LEVELS(PL), .MAX_QUEUES(MQ), .MATCH_LIMIT(ML)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .ob_op_flag(ob_op_flag), .ob_side(ob_side),
    .ob_price(ob_price), .ob_q_index(ob_q_index), .ob_index(ob_index),
    .ob_data(ob_data), .ob_src(ob_src), .ob_matching(ob_matching),
    .busy(busy), .bad_cmd(bad_cmd), .match_timeout(match_timeout)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Requester queues: each port presents its head until handshaken.
  logic [CW-1:0] pq [NP][$];
  logic [NP-1:0] hs = '0;
  int mbudget = 0;  // MATCH cycles for which the book still reports crossing

  function automatic logic [CW-1:0] mk(input logic [2:0] op, input logic sd,
                                       input logic [PRW-1:0] pr, input logic [QW-1:0] q,
                                       input logic [PW-1:0] ix, input logic [DS-1:0] d);
    return {op, sd, pr, q, ix, d};
  endfunction

  always @(negedge clk) hs = req_valid & req_ready;

  always @(posedge clk) begin
    #1;
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) void'(pq[p].pop_front());
      req_valid[p] = (pq[p].size() != 0);
      req_cmd[p*CW +: CW] = (pq[p].size() != 0) ? pq[p][0] : '0;
    end
    hs = '0;
    ob_matching = (mbudget != 0);
  end

  // Reference model: what the op bus must show one cycle after each decision.
  bit started = 0;
  int unsigned m_rr = 0;
  bit m_blocked = 0;   // scheduler owes the book a drain
  int m_k = 0;         // -1: triggering op is on the bus; else match ops issued so far
  logic [2:0] e_flag = '0;
  logic e_side = 0;
  logic [PRW-1:0] e_price = '0;
  logic [QW-1:0] e_q = '0;
  logic [PW-1:0] e_ix = '0;
  logic [DS-1:0] e_data = '0;
  logic [SW-1:0] e_src = '0;
  bit e_bad = 0, e_to = 0;

  function automatic int pick(input logic [NP-1:0] v, input int unsigned rr);
`ifdef OB_SCHED_PRIO_EN
    int unsigned start;
    if (v[0]) return 0;
    start = (rr == 0) ? 1 : rr;
    for (int k = 0; k < NP - 1; k++) begin
      int p;
      p = 1 + ((int'(start) - 1 + k) % (NP - 1));
      if (v[p]) return p;
    end
    return -1;
`else
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (int'(rr) + k) % NP;
      if (v[p]) return p;
    end
    return -1;
`endif
  endfunction

  always @(posedge clk) begin
    int g;
    logic [CW-1:0] c;
    started = 1;
    e_flag = 3'b000;
    e_bad = 0;
    if (reset) begin
      m_rr = 0; m_blocked = 0; m_k = 0;
      e_side = 0; e_price = '0; e_q = '0; e_ix = '0; e_data = '0; e_src = '0; e_to = 0;
    end else if (!m_blocked) begin
      g = pick(req_valid, m_rr);
      if (g >= 0) begin
        c = req_cmd[g*CW +: CW];
`ifdef OB_SCHED_PRIO_EN
        if (g != 0) m_rr = (g + 1) % NP;
`else
        m_rr = (g + 1) % NP;
`endif
        if (c[CW-1] == 1'b0) e_bad = 1;
        else begin
          e_flag = c[CW-1 -: 3];
          {e_side, e_price, e_q, e_ix, e_data} = c[CW-4:0];
          e_src = SW'(g);
          if (e_flag == 3'b100 || e_flag == 3'b101) begin
            m_blocked = 1; m_k = -1;
          end
        end
      end
    end else if (m_k < 0) begin
      m_k = 0;
    end else if (!ob_matching) begin
      m_blocked = 0;
    end else begin
      if (mbudget > 0) mbudget--;
      if (m_k < ML) begin
        e_flag = 3'b101; m_k++;
      end else begin
        e_to = 1; m_blocked = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [NP-1:0] e_rdy;
    int g;
    if (started) begin
      e_rdy = '0;
      g = pick(req_valid, m_rr);
      if (!reset && !m_blocked && g >= 0) e_rdy[g] = 1'b1;
      nvec++;
      if ({ob_op_flag, ob_side, ob_price, ob_q_index, ob_index, ob_data, ob_src,
           busy, bad_cmd, match_timeout, req_ready} !==
          {e_flag, e_side, e_price, e_q, e_ix, e_data, e_src,
           m_blocked, e_bad, e_to, e_rdy}) begin
        nmis++;
        $display("FAIL cycle t=%0t: got flag=%b side=%b pr=%h q=%h ix=%h d=%h src=%0d busy=%b bad=%b to=%b rdy=%b, expected flag=%b side=%b pr=%h q=%h ix=%h d=%h src=%0d busy=%b bad=%b to=%b rdy=%b",
                 $time, ob_op_flag, ob_side, ob_price, ob_q_index, ob_index, ob_data, ob_src,
                 busy, bad_cmd, match_timeout, req_ready,
                 e_flag, e_side, e_price, e_q, e_ix, e_data, e_src,
                 m_blocked, e_bad, e_to, e_rdy);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_op(input string name);
    int n = 0;
    @(negedge clk);
    while (ob_op_flag == 3'b000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check({name, "_timeout"}, 32'(ob_op_flag), 32'h1);
  endtask

  task automatic settle();
    int n = 0;
    while (n < 200 && (busy || ob_op_flag != 3'b000 || req_valid != '0)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("settle_timeout", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cnt;
    int rdy2, bads, ops;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_flag", 32'(ob_op_flag), 32'h0);
    check("reset_timeout", 32'(match_timeout), 32'h0);

    // 1: round robin over ports 0..2 with removes
    for (int i = 0; i < 6; i++)
      for (int p = 0; p < 3; p++) pq[p].push_back(mk(3'b110, 1'b0, 8'(16*p + i), 4'(p), 4'(i), 16'(256*p + i)));
    wait_op("rr");
    for (int i = 0; i < 5; i++) begin
      check("rr_src", 32'(ob_src), 32'(i % 3));
      check("rr_flag", 32'(ob_op_flag), 32'h6);
      check("rr_no_port3", 32'(req_ready[3]), 32'h0);
      @(negedge clk);
    end
    settle();

    // 2: add on port 1, book crossed for three MATCH cycles
    mbudget = 3;
    pq[1].push_back(mk(3'b100, 1'b1, 8'h40, 4'h3, 4'h5, 16'hbeef));
    wait_op("add");
    check("add_flag", 32'(ob_op_flag), 32'h4);
    check("add_price", 32'(ob_price), 32'h40);
    check("add_src", 32'(ob_src), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("drain_flag", 32'(ob_op_flag), (i >= 1 && i <= 3) ? 32'h5 : 32'h0);
      check("drain_price_hold", 32'(ob_price), 32'h40);
    end
    settle();

    // 3: book stuck crossed -> exactly ML match ops then timeout
    mbudget = 1000;
    pq[0].push_back(mk(3'b101, 1'b0, 8'h22, 4'h1, 4'h2, 16'h1234));
    wait_op("stuck");
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ob_op_flag == 3'b101) cnt++;
    end
    check("timeout_match_ops", 32'(cnt), 32'h4);
    check("timeout_sticky", 32'(match_timeout), 32'h1);
    check("timeout_busy", 32'(busy), 32'h0);
    mbudget = 0;
    pq[2].push_back(mk(3'b110, 1'b1, 8'h77, 4'h7, 4'h7, 16'h7777));
    wait_op("post_timeout");
    check("post_timeout_flag", 32'(ob_op_flag), 32'h6);
    check("post_timeout_src", 32'(ob_src), 32'h2);
    settle();

    // 4: illegal op on port 2
    pq[2].push_back(mk(3'b000, 1'b0, 8'h11, 4'h1, 4'h1, 16'h1111));
    rdy2 = 0; bads = 0; ops = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req_ready[2]) rdy2++;
      if (bad_cmd) bads++;
      if (ob_op_flag != 3'b000) ops++;
    end
    check("bad_ready_cycles", 32'(rdy2), 32'h1);
    check("bad_pulse_cycles", 32'(bads), 32'h1);
    check("bad_no_op", 32'(ops), 32'h0);
    settle();

    // 5: reset during a drain
    mbudget = 100;
    pq[1].push_back(mk(3'b100, 1'b0, 8'h55, 4'h5, 4'h5, 16'h5555));
    wait_op("rst_add");
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_flag", 32'(ob_op_flag), 32'h5);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_ready_low", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("rst_flag", 32'(ob_op_flag), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_timeout_clr", 32'(match_timeout), 32'h0);
    mbudget = 0;
    for (int p = 0; p < NP; p++) pq[p].push_back(mk(3'b111, 1'b0, 8'(p), 4'(p), 4'(p), 16'(p)));
    @(posedge clk);
    #1 reset = 1'b0;
    wait_op("rst_rr");
    check("rst_first_src", 32'(ob_src), 32'h0);
    settle();

`ifdef OB_SCHED_PRIO_EN
    // 6: strict priority of port 0 over port 2
    for (int i = 0; i < 5; i++) begin
      pq[0].push_back(mk(3'b111, 1'b0, 8'(i), 4'h0, 4'(i), 16'(i)));
      pq[2].push_back(mk(3'b111, 1'b1, 8'(i + 8), 4'h2, 4'(i), 16'(i + 8)));
    end
    wait_op("prio");
    for (int i = 0; i < 6; i++) begin
      check("prio_src", 32'(ob_src), (i < 5) ? 32'h0 : 32'h2);
      @(negedge clk);
    end
    settle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #500000;
    nmis++;
    $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
